// File: rtl/branch_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// branch_hazard_ctrl_pkg : pipeline opcodes, funct codes and FSM encodings
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package branch_hazard_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STALL   = 2'd1,
    ST_RESOLVE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter : up-counter that sticks at all-ones
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/branch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// branch_hazard_ctrl : ID-stage branch operand hazard stall / resolve sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module branch_hazard_ctrl
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic [5:0]       i_id_op,
  input  logic [5:0]       i_id_funct,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             is_taken,
  input  logic             is_ex_reg_write,
  input  logic             is_ex_mem_read,
  input  logic [4:0]       i_ex_dst,
  input  logic             is_mem_mem_read,
  input  logic [4:0]       i_mem_dst,
  output logic             os_stall_pc,
  output logic             os_stall_ifid,
  output logic             os_bubble_idex,
  output logic             os_flush_ifid,
  output logic             os_pc_sel,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_branch_cnt,
  output logic [CNT_W-1:0] o_taken_cnt
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_cnt;
  logic [1:0] w_cnt_nxt;
  logic [1:0] w_cnt_dec;

  logic w_is_br, w_is_jr, w_is_j, w_ctrl;
  logic w_use_rs, w_use_rt;
  logic w_ex_match, w_mem_match;
  logic [1:0] w_n;
  logic w_active, w_stall, w_resolve;

  // Instruction class decode and which source fields are really read
  assign w_is_br  = (i_id_op == OP_BEQ) || (i_id_op == OP_BNE);
  assign w_is_jr  = (i_id_op == OP_RTYPE) &&
                    ((i_id_funct == FN_JR) || (i_id_funct == FN_JALR));
  assign w_is_j   = (i_id_op == OP_J) || (i_id_op == OP_JAL);
  assign w_ctrl   = w_is_br || w_is_jr || w_is_j;
  assign w_use_rs = w_is_br || w_is_jr;
  assign w_use_rt = w_is_br;

  // $0 is hard-wired, so it can never be a pending producer
  assign w_ex_match  = (w_use_rs && (i_id_rs != 5'd0) && (i_id_rs == i_ex_dst)) ||
                       (w_use_rt && (i_id_rt != 5'd0) && (i_id_rt == i_ex_dst));
  assign w_mem_match = (w_use_rs && (i_id_rs != 5'd0) && (i_id_rs == i_mem_dst)) ||
                       (w_use_rt && (i_id_rt != 5'd0) && (i_id_rt == i_mem_dst));

  always_comb begin
    w_n = 2'd0;
    if (is_ex_mem_read && w_ex_match) begin
      w_n = 2'd2;
    end else if (is_ex_reg_write && w_ex_match) begin
      w_n = 2'd1;
    end else if (is_mem_mem_read && w_mem_match) begin
      w_n = 2'd1;
    end
  end

  assign w_active  = i_enable && !rst;
  assign w_cnt_dec = r_cnt - 2'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_resolve   = 1'b0;
    if (w_active) begin
      case (r_state)
        ST_IDLE: begin
          if (w_ctrl) begin
            if (w_n != 2'd0) begin
              w_stall     = 1'b1;
              w_cnt_nxt   = w_n - 2'd1;
              w_state_nxt = (w_n == 2'd1) ? ST_RESOLVE : ST_STALL;
            end else begin
              w_resolve = 1'b1;
            end
          end
        end
        ST_STALL: begin
          w_stall   = 1'b1;
          w_cnt_nxt = w_cnt_dec;
          if (w_cnt_dec == 2'd0) begin
            w_state_nxt = ST_RESOLVE;
          end
        end
        ST_RESOLVE: begin
          w_resolve   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 2'd0;
    end else if (i_enable) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign os_stall_pc    = w_stall;
  assign os_stall_ifid  = w_stall;
  assign os_bubble_idex = w_stall;
  assign os_pc_sel      = w_resolve && is_taken;
  assign os_flush_ifid  = w_resolve && is_taken;
  assign o_state        = r_state;

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_resolve),
    .o_count (o_branch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_resolve && is_taken),
    .o_count (o_taken_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_branch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_hazard_ctrl : directed self-checking bench for branch_hazard_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_branch_hazard_ctrl;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_enable;
  logic [5:0]       i_id_op;
  logic [5:0]       i_id_funct;
  logic [4:0]       i_id_rs;
  logic [4:0]       i_id_rt;
  logic             is_taken;
  logic             is_ex_reg_write;
  logic             is_ex_mem_read;
  logic [4:0]       i_ex_dst;
  logic             is_mem_mem_read;
  logic [4:0]       i_mem_dst;
  logic             os_stall_pc;
  logic             os_stall_ifid;
  logic             os_bubble_idex;
  logic             os_flush_ifid;
  logic             os_pc_sel;
  logic [1:0]       o_state;
  logic [CNT_W-1:0] o_branch_cnt;
  logic [CNT_W-1:0] o_taken_cnt;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  branch_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_enable        (i_enable),
    .i_id_op         (i_id_op),
    .i_id_funct      (i_id_funct),
    .i_id_rs         (i_id_rs),
    .i_id_rt         (i_id_rt),
    .is_taken        (is_taken),
    .is_ex_reg_write (is_ex_reg_write),
    .is_ex_mem_read  (is_ex_mem_read),
    .i_ex_dst        (i_ex_dst),
    .is_mem_mem_read (is_mem_mem_read),
    .i_mem_dst       (i_mem_dst),
    .os_stall_pc     (os_stall_pc),
    .os_stall_ifid   (os_stall_ifid),
    .os_bubble_idex  (os_bubble_idex),
    .os_flush_ifid   (os_flush_ifid),
    .os_pc_sel       (os_pc_sel),
    .o_state         (o_state),
    .o_branch_cnt    (o_branch_cnt),
    .o_taken_cnt     (o_taken_cnt)
  );

  // Packed as {stall_pc, stall_ifid, bubble, flush, pc_sel, state[1:0]}
  task automatic chk_out(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {os_stall_pc, os_stall_ifid, os_bubble_idex, os_flush_ifid, os_pc_sel, o_state};
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] exp_br,
                         input logic [CNT_W-1:0] exp_tk);
    n_total++;
    assert ((o_branch_cnt === exp_br) && (o_taken_cnt === exp_tk)) n_pass++;
    else $error("FAIL %s observed br=%0h tk=%0h expected br=%0h tk=%0h",
                tag, o_branch_cnt, o_taken_cnt, exp_br, exp_tk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    i_id_op = 6'b001000; i_id_funct = 6'd0; i_id_rs = 5'd0; i_id_rt = 5'd0;
    is_taken = 1'b0; is_ex_reg_write = 1'b0; is_ex_mem_read = 1'b0; i_ex_dst = 5'd0;
    is_mem_mem_read = 1'b0; i_mem_dst = 5'd0;
  endtask

  task automatic set_id(input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt, input logic tk);
    i_id_op = op; i_id_funct = fn; i_id_rs = rs; i_id_rt = rt; is_taken = tk;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    rst = 1'b1; i_enable = 1'b1;
    set_nop();
    tick(); tick();
    rst = 1'b0;
    #1;
    chk_out("reset_outs", 7'b0000000);
    chk_cnt("reset_cnt", 16'd0, 16'd0);

    // BEQ with no producers in flight, taken: resolves in cycle 0
    set_id(6'b000100, 6'd0, 5'd1, 5'd2, 1'b1);
    #1;
    chk_out("beq_free_c0", 7'b0001100);
    tick(); set_nop(); #1;
    chk_cnt("beq_free_cnt", 16'd1, 16'd1);

    // BNE rs=3 with load in EX: N=2, not taken
    set_id(6'b000101, 6'd0, 5'd3, 5'd4, 1'b0);
    is_ex_mem_read = 1'b1; is_ex_reg_write = 1'b1; i_ex_dst = 5'd3;
    #1;
    chk_out("bne_load_c0", 7'b1110000);
    tick();
    chk_out("bne_load_c1", 7'b1110001);
    tick();
    chk_out("bne_load_c2", 7'b0000010);
    tick(); set_nop(); #1;
    chk_out("bne_load_idle", 7'b0000000);
    chk_cnt("bne_load_cnt", 16'd2, 16'd1);

    // JR rs=5 with ALU write in EX: N=1, taken
    set_id(6'b000000, 6'b001000, 5'd5, 5'd0, 1'b1);
    is_ex_reg_write = 1'b1; i_ex_dst = 5'd5;
    #1;
    chk_out("jr_alu_c0", 7'b1110000);
    tick();
    chk_out("jr_alu_c1", 7'b0001110);
    tick(); set_nop();

    // JALR: load in MEM targets rt, which JALR does not read
    set_id(6'b000000, 6'b001001, 5'd6, 5'd7, 1'b1);
    is_mem_mem_read = 1'b1; i_mem_dst = 5'd7;
    #1;
    chk_out("jalr_rt_unused", 7'b0001100);
    tick(); set_nop(); #1;
    chk_cnt("jr_jalr_cnt", 16'd4, 16'd3);

    // BEQ with load in MEM on rt: N=1, not taken
    set_id(6'b000100, 6'd0, 5'd8, 5'd9, 1'b0);
    is_mem_mem_read = 1'b1; i_mem_dst = 5'd9;
    #1;
    chk_out("beq_mem_c0", 7'b1110000);
    tick();
    chk_out("beq_mem_c1", 7'b0000010);
    tick(); set_nop();

    // $0 source and J never stall
    set_id(6'b000100, 6'd0, 5'd0, 5'd10, 1'b0);
    is_ex_mem_read = 1'b1; i_ex_dst = 5'd0;
    #1;
    chk_out("beq_r0", 7'b0000000);
    tick(); set_nop();
    set_id(6'b000010, 6'd0, 5'd11, 5'd11, 1'b1);
    is_ex_mem_read = 1'b1; i_ex_dst = 5'd11;
    #1;
    chk_out("j_nostall", 7'b0001100);
    tick(); set_nop(); #1;
    chk_cnt("r0_j_cnt", 16'd7, 16'd4);

    // Reset in STALL with cnt=1 abandons the branch
    set_id(6'b000101, 6'd0, 5'd3, 5'd4, 1'b1);
    is_ex_mem_read = 1'b1; i_ex_dst = 5'd3;
    tick();
    chk_out("pre_rst_stall", 7'b1110001);
    rst = 1'b1; #1;
    chk_out("rst_high_outs", 7'b0000001);
    tick();
    rst = 1'b0; set_nop(); #1;
    chk_out("post_rst_outs", 7'b0000000);
    chk_cnt("post_rst_cnt", 16'd0, 16'd0);

    // Freeze for 3 cycles in STALL, then finish the sequence
    set_id(6'b000101, 6'd0, 5'd3, 5'd4, 1'b1);
    is_ex_mem_read = 1'b1; i_ex_dst = 5'd3;
    #1;
    chk_out("en_c0", 7'b1110000);
    tick();
    i_enable = 1'b0; #1;
    for (int k = 0; k < 3; k++) begin
      chk_out("frozen_outs", 7'b0000001);
      chk_cnt("frozen_cnt", 16'd0, 16'd0);
      tick();
    end
    i_enable = 1'b1; #1;
    chk_out("reen_stall", 7'b1110001);
    tick();
    chk_out("reen_resolve", 7'b0001110);
    tick(); set_nop(); #1;
    chk_cnt("reen_cnt", 16'd1, 16'd1);

    // Saturation: drive both counters to all-ones, then one more taken BEQ
    set_id(6'b000100, 6'd0, 5'd1, 5'd2, 1'b1);
    for (int k = 0; k < 65534; k++) tick();
    set_nop(); #1;
    chk_cnt("sat_reach", 16'hFFFF, 16'hFFFF);
    set_id(6'b000100, 6'd0, 5'd1, 5'd2, 1'b1);
    #1;
    chk_out("sat_resolve", 7'b0001100);
    tick(); set_nop(); #1;
    chk_cnt("sat_hold", 16'hFFFF, 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
